serial_alu_seq: RTL



---
 rtl/serial_alu_seq_if.sv | 28 ++
 rtl/serial_alu_seq.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/serial_alu_seq_if.sv
// Request/response bundle for the bit-serial ALU sequencer.
// The slave modport is the sequencer side; the master modport is the requester/consumer side.
interface serial_alu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             err;

  modport master (
    output in_valid, alu_op, funct, a, b, out_ready,
    input  in_ready, out_valid, result, zero, overflow, err
  );

  modport slave (
    input  in_valid, alu_op, funct, a, b, out_ready,
    output in_ready, out_valid, result, zero, overflow, err
  );
endinterface

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: decodes ALUOp/funct, runs one 1-bit slice per clock, LSB first.
// Optional macro SLT_OVF_CORRECT_EN makes SLT a true signed compare under subtraction overflow.
module serial_alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  serial_alu_seq_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpOr  = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b110;
  localparam logic [2:0] OpSlt = 3'b111;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_sh_q, result_q;
  logic [2:0]       op_q;
  logic             ill_q, carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q, out_valid_q, zero_q, overflow_q, err_q;

  logic [2:0]       dec_op;
  logic             dec_ill;

  always_comb begin
    dec_op  = OpAdd;
    dec_ill = 1'b0;
    case (bus.alu_op)
      2'b00: dec_op = OpAdd;
      2'b01: dec_op = OpSub;
      2'b10: begin
        case (bus.funct)
          6'b100000: dec_op = OpAdd;
          6'b100010: dec_op = OpSub;
          6'b100100: dec_op = OpAnd;
          6'b100101: dec_op = OpOr;
          6'b101010: dec_op = OpSlt;
          default:   dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // One slice: Binvert = Operation[2], Less tied to 0, AND/OR see raw b.
  logic             a_bit, b_bit, b_eff, sum_bit, cout_bit, res_bit, ovf_bit, set_bit;
  logic [WIDTH-1:0] final_res;

  always_comb begin
    a_bit    = a_q[cnt_q];
    b_bit    = b_q[cnt_q];
    b_eff    = b_bit ^ op_q[2];
    sum_bit  = a_bit ^ b_eff ^ carry_q;
    cout_bit = (a_bit & b_eff) | (a_bit & carry_q) | (b_eff & carry_q);
    case (op_q)
      OpAnd:   res_bit = a_bit & b_bit;
      OpOr:    res_bit = a_bit | b_bit;
      OpSlt:   res_bit = 1'b0;
      default: res_bit = sum_bit;
    endcase
    ovf_bit = carry_q ^ cout_bit;
`ifdef SLT_OVF_CORRECT_EN
    set_bit = sum_bit ^ ovf_bit;
`else
    set_bit = sum_bit;
`endif
    final_res = {res_bit, res_sh_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      res_sh_q    <= '0;
      result_q    <= '0;
      op_q        <= OpAdd;
      ill_q       <= 1'b0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            op_q       <= dec_op;
            ill_q      <= dec_ill;
            carry_q    <= dec_op[2];
            // Illegal requests take a single settle cycle so err appears one clock after accept.
            cnt_q      <= dec_ill ? CntMax : '0;
            in_ready_q <= 1'b0;
            state_q    <= StRun;
          end
        end
        StRun: begin
          res_sh_q <= final_res;
          carry_q  <= cout_bit;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CntMax) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
            if (ill_q) begin
              result_q   <= '0;
              zero_q     <= 1'b1;
              overflow_q <= 1'b0;
              err_q      <= 1'b1;
            end else if (op_q == OpSlt) begin
              result_q   <= {{(WIDTH-1){1'b0}}, set_bit};
              zero_q     <= ~set_bit;
              overflow_q <= 1'b0;
              err_q      <= 1'b0;
            end else begin
              result_q   <= final_res;
              zero_q     <= (final_res == '0);
              overflow_q <= ((op_q == OpAdd) || (op_q == OpSub)) & ovf_bit;
              err_q      <= 1'b0;
            end
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = overflow_q;
  assign bus.err       = err_q;

endmodule
